line_clear_engine: RTL

//   Post-lock row collapse for the playfield. After the game FSM merges a landed

---
 rtl/line_clear_engine.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/line_clear_engine.sv
// ---------------------------------------------------------------------------
// line_clear_engine
//
// Collapses the playfield after a brick has been merged into it. The board is
// scanned bottom-up one row per cycle. Every full row is removed by shifting
// all rows above it down by one, with zeros entering at the top. The same row
// is checked again after a shift, so stacked full rows are all removed.
// The engine counts the rows it removed and keeps a running line total and
// the level derived from that total.
//
// Ports
//   clk            clock
//   rst            asynchronous, active-high reset
//   start          one-cycle request to collapse board_in (only seen in IDLE)
//   board_in       occupancy, cell (x,y) = bit x + y*BOARD_W, row 0 = bottom
//   clear_total    synchronous clear of total_lines and level (new game)
//   busy           engine is working on a request
//   done           one-cycle pulse, board_out and lines_cleared are fresh
//   board_out      collapsed board, held until the next done
//   lines_cleared  rows removed by the last request
//   total_lines    lines cleared since clear_total, saturating at 0xFFFF
//   level          min(total_lines / LINES_PER_LEVEL, MAX_LEVEL)
// ---------------------------------------------------------------------------
module line_clear_engine #(
   parameter int BOARD_W         = 10,
   parameter int BOARD_H         = 20,
   parameter int LINES_PER_LEVEL = 10,
   parameter int MAX_LEVEL       = 14
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [BOARD_W*BOARD_H-1:0] board_in,
   input  logic                       clear_total,
   output logic                       busy,
   output logic                       done,
   output logic [BOARD_W*BOARD_H-1:0] board_out,
   output logic [4:0]                 lines_cleared,
   output logic [15:0]                total_lines,
   output logic [3:0]                 level
);

   localparam logic [4:0] LAST_ROW = 5'(BOARD_H - 1);

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      SHIFT,
      DONE
   } state_t;

   state_t state;
   state_t state_next;

   // Working copy of the board, one packed element per row so a row can be
   // selected and shifted as a unit.
   logic [BOARD_H-1:0][BOARD_W-1:0] work;
   logic [4:0]                      row;
   logic [4:0]                      k;

   logic        row_full;
   logic        enter_done;
   logic [16:0] sum_total;
   logic [15:0] new_total;
   logic [15:0] level_raw;
   logic [3:0]  new_level;

   // The row under the scan pointer, and the single condition that moves the
   // engine into DONE: the top row has been reached and is not full.
   always_comb begin
      row_full   = &work[row];
      enter_done = (state == SCAN) && !row_full && (row == LAST_ROW);
   end

   // Running total with saturation, and the level derived from the updated
   // total so both registers change together on the edge entering DONE.
   always_comb begin
      sum_total = {1'b0, total_lines} + {12'd0, k};
      new_total = sum_total[16] ? 16'hFFFF : sum_total[15:0];
      level_raw = new_total / 16'(LINES_PER_LEVEL);
      new_level = (level_raw > 16'(MAX_LEVEL)) ? 4'(MAX_LEVEL) : level_raw[3:0];
   end

   // State register. Reset aborts any request in flight without a done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. start only matters in IDLE; there is no queueing.
   // A full row always goes through SHIFT and back to SCAN on the same row.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = SCAN;
            end
         end
         SCAN: begin
            if (row_full) begin
               state_next = SHIFT;
            end else if (row == LAST_ROW) begin
               state_next = DONE;
            end
         end
         SHIFT: begin
            state_next = SCAN;
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Status outputs are plain decodes of the registered state, so done is a
   // clean single-cycle pulse.
   always_comb begin
      busy = (state != IDLE);
      done = (state == DONE);
   end

   // Datapath: board capture, scan pointer, row shifting and the registered
   // results. board_out is only written on the edge entering DONE so the
   // renderer never sees a half-collapsed board. clear_total takes priority
   // over the DONE update of the counters but leaves the board result alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         work          <= '0;
         row           <= '0;
         k             <= '0;
         board_out     <= '0;
         lines_cleared <= '0;
         total_lines   <= '0;
         level         <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  work <= board_in;
                  row  <= '0;
                  k    <= '0;
               end
            end
            SCAN: begin
               if (!row_full && (row != LAST_ROW)) begin
                  row <= row + 5'd1;
               end
            end
            SHIFT: begin
               for (int r = 0; r < BOARD_H - 1; r++) begin
                  if (r >= int'(row)) begin
                     work[r] <= work[r+1];
                  end
               end
               work[BOARD_H-1] <= '0;
               k               <= k + 5'd1;
            end
            default: begin
            end
         endcase

         if (enter_done) begin
            board_out     <= work;
            lines_cleared <= k;
         end

         if (clear_total) begin
            total_lines <= '0;
            level       <= '0;
         end else if (enter_done) begin
            total_lines <= new_total;
            level       <= new_level;
         end
      end
   end

endmodule
